// File: rtl/mig_ui_responder.sv
// mig_ui_responder: behavioural stand-in for a MIG user-interface port backed by an
// on-chip 32-bit word memory.
//
// Ports:
//   ui_clk, ui_clk_sync_rst              clock and synchronous active-high reset
//   app_addr, app_cmd, app_en, app_rdy   command channel (000 write, 001 read)
//   app_wdf_data/mask/wren/end/rdy       write-data channel into a WDF_DEPTH-entry FIFO
//   app_rd_data, app_rd_data_valid/end   read return, RD_LATENCY cycles after acceptance
//   init_calib_complete                  high CALIB_CYCLES cycles after reset release
//   protocol_error                       sticky flag for illegal interface usage
module mig_ui_responder #(
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned CALIB_CYCLES   = 16,
  parameter int unsigned WDF_DEPTH      = 4
) (
  input  logic        ui_clk,
  input  logic        ui_clk_sync_rst,
  input  logic [27:0] app_addr,
  input  logic [2:0]  app_cmd,
  input  logic        app_en,
  input  logic [31:0] app_wdf_data,
  input  logic [3:0]  app_wdf_mask,
  input  logic        app_wdf_wren,
  input  logic        app_wdf_end,
  output logic        app_rdy,
  output logic        app_wdf_rdy,
  output logic [31:0] app_rd_data,
  output logic        app_rd_data_valid,
  output logic        app_rd_data_end,
  output logic        init_calib_complete,
  output logic        protocol_error
);

  localparam int unsigned MemWords = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned PtrW     = $clog2(WDF_DEPTH);
  localparam int unsigned CntW     = $clog2(WDF_DEPTH + 1);
  localparam int unsigned CalW     = $clog2(CALIB_CYCLES + 1);

  logic [31:0] mem [MemWords];
  logic [31:0] fifo_data [WDF_DEPTH];
  logic [3:0]  fifo_mask [WDF_DEPTH];

  logic [CalW-1:0]           cal_cnt_q;
  logic                      calib_q;
  logic [PtrW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]           count_q;
  logic                      pend_q;
  logic [MEM_DEPTH_LOG2-1:0] pend_idx_q;
  logic [RD_LATENCY-2:0]     pipe_v_q;
  logic [31:0]               pipe_d_q [RD_LATENCY-1];
  logic                      rd_valid_q;
  logic [31:0]               rd_data_q;
  logic                      perr_q;

  logic                      push, fifo_push, pop, commit, bypass, fifo_nonempty;
  logic                      cmd_acc, wr_acc, rd_acc;
  logic [MEM_DEPTH_LOG2-1:0] cmd_idx, commit_idx;
  logic [31:0]               commit_data;
  logic [3:0]                commit_mask;
  logic                      unused_addr_bits;

  // Only the word-index bits select storage; everything else aliases.
  assign cmd_idx          = app_addr[MEM_DEPTH_LOG2+4:5];
  assign unused_addr_bits = ^{app_addr[27:MEM_DEPTH_LOG2+5], app_addr[4:0]};

  assign app_wdf_rdy         = calib_q && (count_q != CntW'(WDF_DEPTH));
  assign app_rdy             = calib_q && !pend_q;
  assign app_rd_data         = rd_data_q;
  assign app_rd_data_valid   = rd_valid_q;
  assign app_rd_data_end     = rd_valid_q;
  assign init_calib_complete = calib_q;
  assign protocol_error      = perr_q;

  always_comb begin
    fifo_nonempty = (count_q != '0);
    push          = app_wdf_wren && app_wdf_rdy;
    cmd_acc       = app_en && app_rdy;
    wr_acc        = cmd_acc && (app_cmd == 3'b000);
    rd_acc        = cmd_acc && (app_cmd == 3'b001);
    // A pending write may take a beat straight from the input when the FIFO is empty.
    bypass        = pend_q && !fifo_nonempty && push;
    commit        = (wr_acc && fifo_nonempty) || (pend_q && (fifo_nonempty || push));
    pop           = commit && !bypass;
    fifo_push     = push && !bypass;
    commit_idx    = pend_q ? pend_idx_q : cmd_idx;
    commit_data   = bypass ? app_wdf_data : fifo_data[rd_ptr_q];
    commit_mask   = bypass ? app_wdf_mask : fifo_mask[rd_ptr_q];
  end

  // Control state; everything here is cleared by reset.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      cal_cnt_q  <= '0;
      calib_q    <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pipe_v_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      perr_q     <= 1'b0;
    end else begin
      if (!calib_q) begin
        if (cal_cnt_q == CalW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
        else cal_cnt_q <= cal_cnt_q + 1'b1;
      end

      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(fifo_push) - CntW'(pop);

      if (wr_acc && !fifo_nonempty) begin
        pend_q     <= 1'b1;
        pend_idx_q <= cmd_idx;
      end else if (pend_q && commit) begin
        pend_q <= 1'b0;
      end

      pipe_v_q[0] <= rd_acc;
      for (int unsigned i = 1; i < RD_LATENCY - 1; i++) pipe_v_q[i] <= pipe_v_q[i-1];
      rd_valid_q <= pipe_v_q[RD_LATENCY-2];
      if (pipe_v_q[RD_LATENCY-2]) rd_data_q <= pipe_d_q[RD_LATENCY-2];

      if ((cmd_acc && (app_cmd[2:1] != 2'b00)) || (push && !app_wdf_end) ||
          (!calib_q && (app_en || app_wdf_wren))) begin
        perr_q <= 1'b1;
      end
    end
  end

  // Storage: memory survives reset; commits are blocked during a reset cycle so an
  // uncommitted write is discarded rather than landing late.
  always_ff @(posedge ui_clk) begin
    if (commit && !ui_clk_sync_rst) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (!commit_mask[b]) mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
    if (fifo_push) begin
      fifo_data[wr_ptr_q] <= app_wdf_data;
      fifo_mask[wr_ptr_q] <= app_wdf_mask;
    end
    if (rd_acc) pipe_d_q[0] <= mem[cmd_idx];
    for (int unsigned i = 1; i < RD_LATENCY - 1; i++) pipe_d_q[i] <= pipe_d_q[i-1];
  end

endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench for mig_ui_responder with a read-return scoreboard.
module tb_mig_ui_responder;

  localparam int unsigned Lat = 4;

  logic        ui_clk, ui_clk_sync_rst;
  logic [27:0] app_addr;
  logic [2:0]  app_cmd;
  logic        app_en;
  logic [31:0] app_wdf_data;
  logic [3:0]  app_wdf_mask;
  logic        app_wdf_wren, app_wdf_end;
  logic        app_rdy, app_wdf_rdy;
  logic [31:0] app_rd_data;
  logic        app_rd_data_valid, app_rd_data_end;
  logic        init_calib_complete, protocol_error;

  mig_ui_responder #(
    .MEM_DEPTH_LOG2(10),
    .RD_LATENCY    (Lat),
    .CALIB_CYCLES  (16),
    .WDF_DEPTH     (4)
  ) dut (
    .ui_clk             (ui_clk),
    .ui_clk_sync_rst    (ui_clk_sync_rst),
    .app_addr           (app_addr),
    .app_cmd            (app_cmd),
    .app_en             (app_en),
    .app_wdf_data       (app_wdf_data),
    .app_wdf_mask       (app_wdf_mask),
    .app_wdf_wren       (app_wdf_wren),
    .app_wdf_end        (app_wdf_end),
    .app_rdy            (app_rdy),
    .app_wdf_rdy        (app_wdf_rdy),
    .app_rd_data        (app_rd_data),
    .app_rd_data_valid  (app_rd_data_valid),
    .app_rd_data_end    (app_rd_data_end),
    .init_calib_complete(init_calib_complete),
    .protocol_error     (protocol_error)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
  } beat_t;

  rd_t         sb[$];
  beat_t       wq[$];
  logic [31:0] mdl [int];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  initial begin
    ui_clk = 1'b0;
    forever #5 ui_clk = ~ui_clk;
  end

  always @(posedge ui_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [27:0] a);
    return int'((a >> 5) & 28'h3ff);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (!m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Read-return monitor: pops the scoreboard on each valid beat.
  always @(negedge ui_clk) begin
    if (app_rd_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected_valid", {31'd0, app_rd_data_valid}, 32'd0);
      end else begin
        rd_t e;
        e = sb.pop_front();
        chk("rd_data", app_rd_data, e.data);
        chk("rd_cycle", cyc, e.due);
        chk("rd_end", {31'd0, app_rd_data_end}, 32'd1);
      end
    end else if (sb.size() != 0 && cyc >= sb[0].due) begin
      chk("rd_valid_missing", {31'd0, app_rd_data_valid}, 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] m);
    app_wdf_wren = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_end  = 1'b1;
    wq.push_back('{d, m});
    step();
    app_wdf_wren = 1'b0;
  endtask

  // Write command issued with data already in the FIFO.
  task automatic write_cmd(input logic [27:0] a);
    beat_t b;
    logic [31:0] old;
    app_en   = 1'b1;
    app_cmd  = 3'b000;
    app_addr = a;
    step();
    app_en = 1'b0;
    b   = wq.pop_front();
    old = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'd0;
    mdl[widx(a)] = merge(old, b.data, b.mask);
  endtask

  // Drives one read for one cycle; caller lowers app_en.
  task automatic rd(input logic [27:0] a);
    chk("rdy_before_read", {31'd0, app_rdy}, 32'd1);
    app_en   = 1'b1;
    app_cmd  = 3'b001;
    app_addr = a;
    sb.push_back('{mdl[widx(a)], cyc + Lat});
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic calibrate();
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) begin
        chk("calib_early", {31'd0, init_calib_complete}, 32'd0);
        chk("rdy_early", {31'd0, app_rdy}, 32'd0);
        chk("wdf_rdy_early", {31'd0, app_wdf_rdy}, 32'd0);
      end
    end
    chk("calib_done", {31'd0, init_calib_complete}, 32'd1);
    chk("rdy_after_calib", {31'd0, app_rdy}, 32'd1);
    chk("wdf_rdy_after_calib", {31'd0, app_wdf_rdy}, 32'd1);
  endtask

  initial begin
    logic [31:0] d [4];
    ui_clk_sync_rst = 1'b1;
    app_addr = '0; app_cmd = '0; app_en = 1'b0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    step(); step();

    // Reset state
    chk("rst_rdy", {31'd0, app_rdy}, 32'd0);
    chk("rst_wdf_rdy", {31'd0, app_wdf_rdy}, 32'd0);
    chk("rst_valid", {31'd0, app_rd_data_valid}, 32'd0);
    chk("rst_end", {31'd0, app_rd_data_end}, 32'd0);
    chk("rst_calib", {31'd0, init_calib_complete}, 32'd0);
    chk("rst_perr", {31'd0, protocol_error}, 32'd0);
    chk("rst_rd_data", app_rd_data, 32'd0);

    ui_clk_sync_rst = 1'b0;
    calibrate();

    // Data first, then command
    push_beat(32'hAABBCCDD, 4'b0000);
    write_cmd(28'h20);
    chk("rdy_no_pending", {31'd0, app_rdy}, 32'd1);
    rd(28'h20);
    app_en = 1'b0;
    drain();
    chk("rd_data_hold", app_rd_data, 32'hAABBCCDD);

    // Command first: write stays pending until its data arrives
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h40;
    step();
    app_en = 1'b0;
    chk("pending_rdy_low", {31'd0, app_rdy}, 32'd0);
    step();
    step();
    chk("pending_rdy_still_low", {31'd0, app_rdy}, 32'd0);
    app_wdf_wren = 1'b1; app_wdf_data = 32'h11223344; app_wdf_mask = 4'b0000;
    app_wdf_end = 1'b1;
    step();
    app_wdf_wren = 1'b0;
    mdl[widx(28'h40)] = 32'h11223344;
    chk("pending_rdy_back", {31'd0, app_rdy}, 32'd1);
    push_beat(32'hFFFFFFFF, 4'b0011);
    write_cmd(28'h40);
    chk("model_masked", mdl[widx(28'h40)], 32'hFFFF3344);
    rd(28'h40);
    app_en = 1'b0;
    drain();

    // Fill the FIFO, drain it with commands, then back-to-back reads
    d[0] = 32'h01010101; d[1] = 32'h20202020; d[2] = 32'hC0DE4040; d[3] = 32'h60606066;
    for (int i = 0; i < 4; i++) push_beat(d[i], 4'b0000);
    chk("fifo_full", {31'd0, app_wdf_rdy}, 32'd0);
    write_cmd(28'h0);
    chk("fifo_not_full", {31'd0, app_wdf_rdy}, 32'd1);
    write_cmd(28'h20);
    write_cmd(28'h40);
    write_cmd(28'h60);
    for (int i = 0; i < 4; i++) rd(28'(i * 32));
    app_en = 1'b0;
    drain();

    // Address aliasing and illegal command
    push_beat(32'h5A5A1234, 4'b0000);
    write_cmd(28'h8000);
    rd(28'h0);
    app_en = 1'b0;
    drain();
    chk("perr_clear", {31'd0, protocol_error}, 32'd0);
    app_en = 1'b1; app_cmd = 3'b010; app_addr = 28'h20;
    step();
    app_en = 1'b0;
    chk("perr_set", {31'd0, protocol_error}, 32'd1);
    for (int i = 0; i < 6; i++) step();
    chk("perr_sticky", {31'd0, protocol_error}, 32'd1);

    // Reset one cycle after a read is accepted: no return expected
    app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h20;
    step();
    app_en = 1'b0;
    ui_clk_sync_rst = 1'b1;
    step(); step();
    chk("rst2_perr", {31'd0, protocol_error}, 32'd0);
    chk("rst2_calib", {31'd0, init_calib_complete}, 32'd0);
    chk("rst2_rd_data", app_rd_data, 32'd0);
    ui_clk_sync_rst = 1'b0;
    calibrate();
    rd(28'h20);
    rd(28'h40);
    app_en = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
